// File: rtl/alu_rr_pkg.sv
// Shared opcode constants, opcode legality check and scheduler state type
// for the two-requester ALU scheduler.
package alu_rr_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction

endpackage

// File: rtl/alu.sv
// Existing unsigned ALU: add/sub/and/or/xor/sra/srl/nor.
// sra is unsigned here, so it matches srl; oversized shifts give 0.
module alu
    import alu_rr_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int OP_BITS = 6
) (
    input  logic [N_BITS-1:0]  data_a_i,
    input  logic [N_BITS-1:0]  data_b_i,
    input  logic [OP_BITS-1:0] op_i,
    output logic [N_BITS-1:0]  result_o
);

    // Pure combinational operation select
    always_comb begin
        result_o = '0;
        unique case (op_i)
            OP_ADD:  result_o = data_a_i + data_b_i;
            OP_SUB:  result_o = data_a_i - data_b_i;
            OP_AND:  result_o = data_a_i & data_b_i;
            OP_OR:   result_o = data_a_i | data_b_i;
            OP_XOR:  result_o = data_a_i ^ data_b_i;
            OP_SRA:  result_o = data_a_i >> data_b_i;
            OP_SRL:  result_o = data_a_i >> data_b_i;
            OP_NOR:  result_o = ~(data_a_i | data_b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched_rr_arb2.sv
// Two-way round-robin arbiter; last_grant resets to 1 so
// requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q;
    logic last_d;

    // Pick winner: sole requester, or the one not granted last time
    always_comb begin
        gnt_id_o = 1'b0;
        if (req_i[0] && req_i[1]) begin
            gnt_id_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_id_o = 1'b1;
        end
        gnt_o  = 2'b00;
        if (req_i != 2'b00) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
        last_d = accept_i ? gnt_id_o : last_q;
    end

    // Remember the most recently accepted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// Optional ALU_RR_STATS_EN adds per-requester and error response counters.
module alu_rr_sched
    import alu_rr_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int OP_BITS = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [N_BITS-1:0]  req0_d0,
    input  logic [N_BITS-1:0]  req0_d1,
    input  logic [OP_BITS-1:0] req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [N_BITS-1:0]  req1_d0,
    input  logic [N_BITS-1:0]  req1_d1,
    input  logic [OP_BITS-1:0] req1_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [N_BITS-1:0]  rsp_data,
    output logic               rsp_err
`ifdef ALU_RR_STATS_EN
    ,
    output logic [15:0]        stat0_cnt,
    output logic [15:0]        stat1_cnt,
    output logic [7:0]         stat_err_cnt
`endif
);

    sched_state_t       state_q, state_d;
    logic [N_BITS-1:0]  a_q, a_d;
    logic [N_BITS-1:0]  b_q, b_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic               id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [N_BITS-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic              idle;
    logic              accept;
    logic              fire;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic [N_BITS-1:0] alu_res;

    assign idle   = (state_q == IDLE);
    assign accept = idle && (req0_valid || req1_valid);
    assign fire   = rsp_valid_q && rsp_ready;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req0_ready = idle && gnt[0];
    assign req1_ready = idle && gnt[1];

    alu #(
        .N_BITS  (N_BITS),
        .OP_BITS (OP_BITS)
    ) u_alu (
        .data_a_i (a_q),
        .data_b_i (b_q),
        .op_i     (op_q),
        .result_o (alu_res)
    );

    // Issue / execute / hold sequencing and response capture
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = gnt_id ? req1_d0 : req0_d0;
                    b_d     = gnt_id ? req1_d1 : req0_d1;
                    op_d    = gnt_id ? req1_op : req0_op;
                    id_d    = gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = ~is_legal_op(op_q);
                rsp_data_d  = is_legal_op(op_q) ? alu_res : '0;
                state_d     = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_RR_STATS_EN
    logic [15:0] s0_q, s0_d;
    logic [15:0] s1_q, s1_d;
    logic [7:0]  se_q, se_d;

    // Saturating counters of handshaken responses
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        se_d = se_q;
        if (fire) begin
            if (!rsp_id_q && s0_q != 16'hFFFF) s0_d = s0_q + 16'd1;
            if (rsp_id_q && s1_q != 16'hFFFF)  s1_d = s1_q + 16'd1;
            if (rsp_err_q && se_q != 8'hFF)    se_d = se_q + 8'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q <= '0;
            s1_q <= '0;
            se_q <= '0;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            se_q <= se_d;
        end
    end

    assign stat0_cnt    = s0_q;
    assign stat1_cnt    = s1_q;
    assign stat_err_cnt = se_q;
`else
    logic unused_fire;
    assign unused_fire = fire;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: vector table plus directed
// sequences for latency, ties, backpressure, reset-in-HOLD and stats.
module tb_alu_rr_sched;
    import alu_rr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_d0, req0_d1;
    logic [5:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_d0, req1_d1;
    logic [5:0] req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0] rsp_data;
`ifdef ALU_RR_STATS_EN
    logic [15:0] stat0_cnt, stat1_cnt;
    logic [7:0]  stat_err_cnt;
`endif

    always #5 clk = ~clk;

    alu_rr_sched #(.N_BITS(8), .OP_BITS(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_d0    (req0_d0),
        .req0_d1    (req0_d1),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_d0    (req1_d0),
        .req1_d1    (req1_d1),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
`ifdef ALU_RR_STATS_EN
        ,
        .stat0_cnt    (stat0_cnt),
        .stat1_cnt    (stat1_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    typedef struct {
        logic       id;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [5:0] op;
        logic [7:0] ed;
        logic       ee;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[14];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each handshaken response with the queue head
    always @(negedge clk) begin
        if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp id=%0d data=%0h required=none",
                         rsp_id, rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    task automatic drive(input logic id, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_d0 = a; req1_d1 = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_d0 = a; req0_d1 = b; req0_op = op;
        end
    endtask

    // Drive one command, wait for its grant, optionally record expectation
    task automatic issue(input logic id, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] ed, input logic ee,
                         input bit push);
        int n;
        logic rdy;
        @(posedge clk); #1;
        drive(id, a, b, op);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = id ? req1_ready : req0_ready;
        end while (!rdy && n < 40);
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL grant_timeout id=%0d actual=0 required=1", id);
        end else if (push) begin
            sb.push_back('{id, ed, ee});
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'h05, 8'h03, OP_ADD, 8'h08, 1'b0};
        tbl[1]  = '{1'b1, 8'h10, 8'h20, OP_SUB, 8'hF0, 1'b0};
        tbl[2]  = '{1'b0, 8'hF0, 8'h0F, OP_OR,  8'hFF, 1'b0};
        tbl[3]  = '{1'b1, 8'h81, 8'h01, OP_SRA, 8'h40, 1'b0};
        tbl[4]  = '{1'b0, 8'h81, 8'h01, OP_SRL, 8'h40, 1'b0};
        tbl[5]  = '{1'b1, 8'hCC, 8'hAA, OP_AND, 8'h88, 1'b0};
        tbl[6]  = '{1'b0, 8'hCC, 8'hAA, OP_XOR, 8'h66, 1'b0};
        tbl[7]  = '{1'b1, 8'h0F, 8'hF0, OP_NOR, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'h3F, 8'h00, 6'b111111, 8'h00, 1'b1};
        tbl[9]  = '{1'b1, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 8'h80, 8'h08, OP_SRL, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 8'h80, 8'h07, OP_SRL, 8'h01, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0};
        tbl[13] = '{1'b1, 8'h12, 8'h34, 6'b000000, 8'h00, 1'b1};

        reset = 1'b1;
        req0_valid = 1'b0; req0_d0 = '0; req0_d1 = '0; req0_op = '0;
        req1_valid = 1'b0; req1_d0 = '0; req1_d1 = '0; req1_op = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_id", rsp_id, 1'b0);
        chk("rst_data", rsp_data, 8'h00);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_r0_ready", req0_ready, 1'b0);
        chk("rst_r1_ready", req1_ready, 1'b0);

        // First transaction and its latency
        @(posedge clk); #1;
        drive(1'b0, 8'h05, 8'h03, OP_ADD);
        @(negedge clk);
        chk("acc_r0_ready", req0_ready, 1'b1);
        chk("acc_r1_ready", req1_ready, 1'b0);
        sb.push_back('{1'b0, 8'h08, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("exec_valid", rsp_valid, 1'b0);
        chk("exec_r0_ready", req0_ready, 1'b0);
        @(negedge clk);
        chk("lat_valid", rsp_valid, 1'b1);
        drain();

        // Vector table
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].id, tbl[i].d0, tbl[i].d1, tbl[i].op,
                  tbl[i].ed, tbl[i].ee, 1'b1);
        end
        drain();

        // Continuous tie: grants alternate 0,1,0,1
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 8'hF0, 8'h0F, OP_OR);
        drive(1'b1, 8'h10, 8'h20, OP_SUB);
        for (int g = 0; g < 4; g++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(req0_ready || req1_ready) && n < 20);
            chk("tie_grant_id", req1_ready, g % 2);
            chk("tie_onehot", req0_ready ^ req1_ready, 1'b1);
            if (req1_ready) sb.push_back('{1'b1, 8'hF0, 1'b0});
            else if (req0_ready) sb.push_back('{1'b0, 8'hFF, 1'b0});
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure: response held stable, no grants while held
        rsp_ready = 1'b0;
        issue(1'b1, 8'h81, 8'h01, OP_SRA, 8'h40, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 8'h22, 8'h11, OP_ADD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, 8'h40);
            chk("hold_id", rsp_id, 1'b1);
            chk("hold_r0_ready", req0_ready, 1'b0);
            chk("hold_r1_ready", req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hold_valid", rsp_valid, 1'b0);
        chk("post_hold_r0_ready", req0_ready, 1'b1);
        sb.push_back('{1'b0, 8'h33, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain();

        // Illegal op then legal NOR
        issue(1'b0, 8'h55, 8'h01, 6'b111111, 8'h00, 1'b1, 1'b1);
        issue(1'b0, 8'h0F, 8'hF0, OP_NOR, 8'h00, 1'b0, 1'b1);
        drain();

        // Reset during HOLD discards the response; tie then goes to 0
        rsp_ready = 1'b0;
        issue(1'b1, 8'h01, 8'h02, OP_ADD, 8'h03, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_data", rsp_data, 8'h00);
        chk("mid_rst_id", rsp_id, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 8'h07, 8'h01, OP_ADD);
        drive(1'b1, 8'h07, 8'h01, OP_SUB);
        @(negedge clk);
        chk("rst_tie_r0", req0_ready, 1'b1);
        chk("rst_tie_r1", req1_ready, 1'b0);
        sb.push_back('{1'b0, 8'h08, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

`ifdef ALU_RR_STATS_EN
        do_reset();
        @(negedge clk);
        chk("stat0_rst", stat0_cnt, 16'd0);
        chk("stat_err_rst", stat_err_cnt, 8'd0);
        issue(1'b0, 8'h01, 8'h01, OP_ADD, 8'h02, 1'b0, 1'b1);
        issue(1'b1, 8'h03, 8'h01, OP_SUB, 8'h02, 1'b0, 1'b1);
        issue(1'b0, 8'h01, 8'h01, 6'b010101, 8'h00, 1'b1, 1'b1);
        issue(1'b1, 8'h0C, 8'h0A, OP_XOR, 8'h06, 1'b0, 1'b1);
        issue(1'b0, 8'hF0, 8'h04, OP_SRL, 8'h0F, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        @(negedge clk);
        chk("stat0_cnt", stat0_cnt, 16'd3);
        chk("stat1_cnt", stat1_cnt, 16'd2);
        chk("stat_err_cnt", stat_err_cnt, 8'd1);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
